// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the decode-side instruction fetch queue.
//   If_id_pkt_t : one fetch slot as registered by fetch (pc, npc, inst, valid, bp info)
//   stall_e     : dec_stall encoding seen by fetch
//   IFQ_DEPTH   : default queue depth
package inst_fetch_queue_pkg;

    localparam int unsigned IFQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic        valid;
        logic        bp_hit;
        logic [1:0]  bp_state;
    } If_id_pkt_t;

    // 10 asks fetch to restart from slot 1, 01 asks it to repeat the whole group.
    typedef enum logic [1:0] {
        STALL_NONE = 2'b00,
        STALL_ALL  = 2'b01,
        STALL_S1   = 2'b10
    } stall_e;

endpackage

// File: rtl/ifq_credit.sv
// Credit check for the fetch queue (purely combinational).
//   count_next_i : occupancy after this cycle's dequeue/enqueue
//   stall_d1_i   : dec_stall issued last cycle (bounds the group arriving next cycle)
//   dec_stall_o  : backpressure for fetch
module ifq_credit
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic [CW-1:0] count_next_i,
    input  stall_e        stall_d1_i,
    output stall_e        dec_stall_o
);

    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);
    localparam logic [CW:0] One    = (CW + 1)'(1);
    localparam logic [CW:0] Two    = (CW + 1)'(2);

    logic [CW:0] new_d1;
    logic [CW:0] used;
    logic [CW:0] avail;

    always_comb begin
        // New instructions the already-requested group can still bring.
        case (stall_d1_i)
            STALL_NONE: new_d1 = Two;
            STALL_S1:   new_d1 = One;
            default:    new_d1 = '0;
        endcase

        used  = {1'b0, count_next_i} + new_d1;
        avail = (used >= DepthW) ? '0 : DepthW - used;

        if (avail >= Two) begin
            dec_stall_o = STALL_NONE;
        end else if (avail == One) begin
            dec_stall_o = STALL_S1;
        end else begin
            dec_stall_o = STALL_ALL;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Decode-side receiver for the 2-wide fetch packet stream.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   br_taken_i    : flush (mispredict/exception), same signal fetch sees
//   if_id_pkt_i   : registered 2-slot fetch group
//   dec_stall_o   : backpressure to fetch (00 none, 10 slot-1 refetch, 01 full refetch)
//   id_take_i     : thermometer dequeue request from decode (00, 01, 11)
//   id_pkt_o      : head and head+1 entries; .valid marks occupancy
//   ifq_count_o   : occupancy
//   ovf_err_o     : sticky, an enqueue was dropped for lack of space
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             br_taken_i,
    input  If_id_pkt_t [1:0] if_id_pkt_i,
    output logic [1:0]       dec_stall_o,
    input  logic [1:0]       id_take_i,
    output If_id_pkt_t [1:0] id_pkt_o,
    output logic [CW-1:0]    ifq_count_o,
    output logic             ovf_err_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    If_id_pkt_t    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, head_p1;
    logic [PW-1:0] tail_q, tail_d, tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] space;
    logic          ovf_q, ovf_d;
    stall_e        stall_d1_q, stall_d1_d;
    stall_e        stall_d2_q, stall_d2_d;
    stall_e        credit_stall;
    stall_e        dec_stall;

    logic          deq0, deq1;
    logic [1:0]    ndeq, nreq, nenq;
    logic          drop0, drop1;
    logic          acc0, acc1;
    logic          wr0, wr1;
    If_id_pkt_t    wr_pkt0;

    assign head_p1 = head_q + PW'(1);
    assign tail_p1 = tail_q + PW'(1);

    always_comb begin
        // Only occupied entries dequeue; slot 1 needs slot 0 to go too.
        deq0 = id_take_i[0] && (count_q != '0);
        deq1 = id_take_i[1] && deq0 && (count_q >= CW'(2));
        ndeq = {1'b0, deq0} + {1'b0, deq1};

        // A stall two cycles back means fetch is replaying what we already hold.
        drop0 = (stall_d2_q == STALL_ALL) || (stall_d2_q == STALL_S1);
        drop1 = (stall_d2_q == STALL_ALL);
        acc0  = if_id_pkt_i[0].valid && !drop0;
        acc1  = if_id_pkt_i[1].valid && !drop1;
        nreq  = {1'b0, acc0} + {1'b0, acc1};

        // Compact accepted slots so the first one always lands at tail.
        wr_pkt0 = acc0 ? if_id_pkt_i[0] : if_id_pkt_i[1];

        space = CW'(DEPTH) - count_q + CW'(ndeq);
        nenq  = nreq;
        ovf_d = ovf_q;
        if (CW'(nreq) > space) begin
            nenq  = space[1:0];
            ovf_d = 1'b1;
        end

        wr0     = (nenq != 2'd0);
        wr1     = (nenq == 2'd2);
        count_d = count_q - CW'(ndeq) + CW'(nenq);
        head_d  = head_q + PW'(ndeq);
        tail_d  = tail_q + PW'(nenq);

        // Flush beats both dequeue and enqueue.
        if (br_taken_i) begin
            wr0     = 1'b0;
            wr1     = 1'b0;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            ovf_d   = ovf_q;
        end
    end

    ifq_credit #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_credit (
        .count_next_i (count_d),
        .stall_d1_i   (stall_d1_q),
        .dec_stall_o  (credit_stall)
    );

    assign dec_stall   = br_taken_i ? STALL_NONE : credit_stall;
    assign dec_stall_o = dec_stall;

    always_comb begin
        stall_d1_d = dec_stall;
        stall_d2_d = stall_d1_q;
        if (br_taken_i) begin
            stall_d1_d = STALL_NONE;
            stall_d2_d = STALL_NONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            stall_d1_q <= STALL_NONE;
            stall_d2_q <= STALL_NONE;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            stall_d1_q <= stall_d1_d;
            stall_d2_q <= stall_d2_d;
        end
    end

    // Payload storage needs no reset; occupancy comes from count_q.
    always_ff @(posedge clk_i) begin
        if (wr0) begin
            mem_q[tail_q] <= wr_pkt0;
        end
        if (wr1) begin
            mem_q[tail_p1] <= if_id_pkt_i[1];
        end
    end

    always_comb begin
        id_pkt_o[0]       = mem_q[head_q];
        id_pkt_o[0].valid = (count_q != '0);
        id_pkt_o[1]       = mem_q[head_p1];
        id_pkt_o[1].valid = (count_q >= CW'(2));
    end

    assign ifq_count_o = count_q;
    assign ovf_err_o   = ovf_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a small fetch model that honours
// dec_stall refetch semantics (01 repeat group, 10 restart at slot 1) and br_taken.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             br_taken = 1'b0;
    If_id_pkt_t [1:0] pkt;
    logic [1:0]       dec_stall;
    logic [1:0]       id_take = 2'b00;
    If_id_pkt_t [1:0] id_pkt;
    logic [CW-1:0]    ifq_count;
    logic             ovf_err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] fpc = 32'h0;
    logic [31:0] br_addr = 32'h0;
    bit          fetch_en = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .br_taken_i  (br_taken),
        .if_id_pkt_i (pkt),
        .dec_stall_o (dec_stall),
        .id_take_i   (id_take),
        .id_pkt_o    (id_pkt),
        .ifq_count_o (ifq_count),
        .ovf_err_o   (ovf_err)
    );

    function automatic If_id_pkt_t mk(input logic [31:0] pc, input logic v);
        If_id_pkt_t p;
        p.pc       = pc;
        p.npc      = pc + 32'd2;
        p.inst     = {16'hA5A5, pc[15:0]};
        p.valid    = v;
        p.bp_hit   = 1'b0;
        p.bp_state = 2'b01;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_heads(input string tag, input logic [31:0] pc0);
        check({tag, ".valid"}, {30'd0, id_pkt[1].valid, id_pkt[0].valid}, 32'd3);
        check({tag, ".pc0"}, id_pkt[0].pc, pc0);
        check({tag, ".pc1"}, id_pkt[1].pc, pc0 + 32'd2);
    endtask

    // One clock: sample fetch-visible signals mid-cycle, then advance the fetch model.
    task automatic tick();
        logic [1:0] st;
        logic       br;
        @(negedge clk);
        st = dec_stall;
        br = br_taken;
        @(posedge clk);
        #1;
        id_take  = 2'b00;
        br_taken = 1'b0;
        if (fetch_en) begin
            if (br) begin
                pkt[0] = mk(32'h0, 1'b0);
                pkt[1] = mk(32'h0, 1'b0);
                fpc    = br_addr;
            end else begin
                pkt[0] = mk(fpc, 1'b1);
                pkt[1] = mk(fpc + 32'd2, 1'b1);
                case (st)
                    2'b00:   fpc = fpc + 32'd4;
                    2'b10:   fpc = fpc + 32'd2;
                    default: fpc = fpc;
                endcase
            end
        end
    endtask

    logic [31:0] drain_pc [5];

    initial begin
        drain_pc = '{32'h6, 32'hA, 32'hE, 32'h12, 32'h16};
        pkt[0] = mk(32'h0, 1'b0);
        pkt[1] = mk(32'h0, 1'b0);

        // Reset held across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst.dec_stall", {30'd0, dec_stall}, 32'h0);
        check("rst.valid", {30'd0, id_pkt[1].valid, id_pkt[0].valid}, 32'h0);
        check("rst.count", {28'd0, ifq_count}, 32'd0);
        check("rst.ovf", {31'd0, ovf_err}, 32'd0);

        rst_n    = 1'b1;
        fetch_en = 1'b1;

        // Fill with no dequeue: queue ends up holding 0x0..0xE.
        repeat (7) tick();
        #1;
        check("fill.count", {28'd0, ifq_count}, 32'd8);
        check("fill.dec_stall", {30'd0, dec_stall}, 32'h1);
        check("fill.ovf", {31'd0, ovf_err}, 32'd0);
        check_heads("fill.head", 32'h0);

        // Take two; credit reopens, replay of 0xC/0xE is dropped, 0x10/0x12 land once.
        id_take = 2'b11;
        #1;
        check("drain.dec_stall", {30'd0, dec_stall}, 32'h0);
        tick();
        #1;
        check("drain.count", {28'd0, ifq_count}, 32'd6);
        check("drain.dec_stall2", {30'd0, dec_stall}, 32'h1);
        tick();
        tick();
        #1;
        check("resume.count", {28'd0, ifq_count}, 32'd8);
        check_heads("resume.head", 32'h4);

        // Take one: avail=1 -> slot-1 refetch, then slot 0 dropped, slot 1 kept.
        id_take = 2'b01;
        #1;
        check("part.dec_stall", {30'd0, dec_stall}, 32'h2);
        tick();
        #1;
        check("part.count_a", {28'd0, ifq_count}, 32'd7);
        check("part.dec_stall_a", {30'd0, dec_stall}, 32'h1);
        tick();
        #1;
        check("part.count_b", {28'd0, ifq_count}, 32'd7);
        check("part.in_pc0", pkt[0].pc, 32'h12);
        tick();
        #1;
        check("part.count_c", {28'd0, ifq_count}, 32'd8);

        // Drain in pairs: order must be gap-free with no duplicates.
        for (int i = 0; i < 5; i++) begin
            id_take = 2'b11;
            #1;
            check_heads($sformatf("seq%0d", i), drain_pc[i]);
            tick();
        end
        #1;
        check("seq.count", {28'd0, ifq_count}, 32'd4);
        check_heads("seq.head", 32'h1A);

        // Build occupancy 5 before flushing.
        id_take = 2'b01;
        #1;
        check("pre_flush.dec_stall", {30'd0, dec_stall}, 32'h2);
        tick();
        #1;
        check("pre_flush.count", {28'd0, ifq_count}, 32'd5);

        // Flush with a simultaneous take: flush wins.
        br_addr  = 32'h100;
        br_taken = 1'b1;
        id_take  = 2'b11;
        #1;
        check("flush.dec_stall", {30'd0, dec_stall}, 32'h0);
        tick();
        #1;
        check("flush.count", {28'd0, ifq_count}, 32'd0);
        check("flush.valid", {30'd0, id_pkt[1].valid, id_pkt[0].valid}, 32'h0);
        check("flush.in_valid", {31'd0, pkt[0].valid}, 32'd0);
        tick();
        #1;
        check("flush.count2", {28'd0, ifq_count}, 32'd0);
        fetch_en = 1'b0;
        tick();
        #1;
        check("target.count", {28'd0, ifq_count}, 32'd2);
        check_heads("target.head", 32'h100);

        // Predicted-taken group: only slot 0 valid.
        pkt[0] = mk(32'h200, 1'b1);
        pkt[1] = mk(32'h202, 1'b0);
        #1;
        check("s1inv.dec_stall", {30'd0, dec_stall}, 32'h0);
        tick();
        pkt[0] = mk(32'h0, 1'b0);
        pkt[1] = mk(32'h0, 1'b0);
        #1;
        check("s1inv.count", {28'd0, ifq_count}, 32'd3);
        check("s1inv.ovf", {31'd0, ovf_err}, 32'd0);

        // Asynchronous reset between edges.
        rst_n = 1'b0;
        #1;
        check("arst.count", {28'd0, ifq_count}, 32'd0);
        check("arst.dec_stall", {30'd0, dec_stall}, 32'h0);
        check("arst.valid", {30'd0, id_pkt[1].valid, id_pkt[0].valid}, 32'h0);
        rst_n = 1'b1;
        tick();
        #1;
        check("post_rst.count", {28'd0, ifq_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Decode-side receiver for the 2-wide fetch packet stream. Buffers If_id_pkt_t groups in a small FIFO and presents up to 2 instructions per cycle to decode. Generates dec_stall backpressure using the fetch refetch semantics: 01 refetches the whole group, 10 refetches from slot 1. Drops the replayed instructions that each stall causes, and flushes on br_taken.

Parameters:
DEPTH, 8, queue entries; power of 2, at least 4
CW, $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
br_taken  in  1  mispredict/exception flush, same signal that fetch sees
if_id_pkt  in  If_id_pkt_t[1:0]  registered fetch group; fields pc, npc, inst, valid, bp_hit, bp_state
dec_stall  out  2  backpressure to fetch: 00 none, 10 slot-1 refetch, 01 full refetch
id_take  in  2  decode consumes head entries; legal values 00, 01, 11 (thermometer)
id_pkt  out  If_id_pkt_t[1:0]  head and head+1 entries; .valid = entry occupied
ifq_count  out  CW  current occupancy
ovf_err  out  1  sticky: an enqueue was dropped for lack of space

Behaviour:
- Reset (rst=0, async): count=0, head=tail=0, dec_stall=00, id_pkt valid=00, ovf_err=0, stall history regs=00.
- Latency: an accepted slot becomes visible on id_pkt the cycle after the edge that writes it. No enqueue-to-dequeue bypass.
- id_pkt is combinational from storage at head/head+1.
- id_take asserted on an unoccupied slot is ignored; only occupied entries dequeue.
- Dequeue and enqueue in the same cycle are both legal; count_next = count - ndeq + nenq.
- Replay drop uses stall_d2, the dec_stall value from 2 cycles earlier, qualified by history:
  - stall_d2=01: drop both incoming slots (exact duplicate of the previous group).
  - stall_d2=10: drop incoming slot 0 (duplicate of previous slot 1); slot 1 is new.
  - stall_d2=00: no drop.
- Enqueue: incoming slots that are valid and not dropped are compacted in order (slot 0 first) at tail. Pointers wrap modulo DEPTH.
  - Slot 1 invalid (slot 0 predicted taken): only slot 0 is written.
- Credit and stall, recomputed every cycle (combinational):
  - new_d1 = number of new instructions the group arriving next cycle can bring: 2 if stall_d1=00, 1 if 10, 0 if 01.
  - avail = DEPTH - count_next - new_d1, saturating at 0.
  - dec_stall = 00 if avail >= 2; 10 if avail = 1; 01 if avail = 0.
  - Invariant: under legal stimulus, no valid non-duplicate slot is ever refused.
- Overflow (illegal stimulus): slots beyond free space are discarded and ovf_err sets; it clears only on reset.
- Flush (br_taken=1) at edge:
  - Clears count, head and tail; all entries become invalid.
  - Forces stall_d1 and stall_d2 to 00.
  - Incoming slots that cycle are discarded.
  - dec_stall that cycle is don't-care (fetch gives br_taken priority) but is driven 00.
  - Next cycle's packet arrives valid=0; the target group arrives 2 cycles after flush and is accepted with no drop.
- Flush and id_take in the same cycle: flush wins; nothing dequeues.
- Async reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Decomposition:
- Shared package: If_id_pkt_t (existing), IFQ_DEPTH default, and a localparam enum for the stall encoding (STALL_NONE=00, STALL_S1=10, STALL_ALL=01).
- One sub-module, ifq_credit: combinational. Takes count_next and stall_d1; produces dec_stall. Lets the credit rule be checked in isolation.
- Storage, pointers, drop logic and the stall history pipeline stay in inst_fetch_queue.

Test Plan:
1. Reset: hold rst=0, pulse clk -> dec_stall=00, id_pkt valid=00, ifq_count=0, ovf_err=0.
2. Fill: fetch model streams pc 0x0,0x2,0x4,... every cycle, id_take=00 -> queue holds exactly pc 0x0..0xE in order, ifq_count=8, dec_stall settles at 01, ovf_err=0, no duplicate pc.
3. Drain/resume: from case 2, id_take=11 for 1 cycle -> id_pkt pc 0x0,0x2 retire; later enqueues are 0x10,0x12 exactly once, with no 0xE duplicate.
4. Partial stall: count such that avail=1 -> dec_stall=10; 2 cycles later incoming slot 0 (pc X) is dropped and slot 1 (X+2) is enqueued -> ifq_count +1.
5. Flush: ifq_count=5, br_taken=1 with br_addr=0x100 -> next cycle ifq_count=0 and valid=00; the 0x100/0x102 group is enqueued 2 cycles after flush with no drop.
6. Slot-1 invalid plus async reset: group with valid=10 -> ifq_count +1. Then drop rst between edges -> ifq_count=0 and dec_stall=00 before the next posedge.
